// File: rtl/keypad_emulator.sv
// rtl/keypad_emulator.sv - 4x4 matrix keypad emulator replaying queued key codes as timed presses
//
// Plays the switch side of a row-strobe/column-sense keypad. Key codes pushed on
// key_valid/key_ready are queued and replayed one at a time. Each key is held for
// PRESS_CYCLES and then released for GAP_CYCLES. While a key is held, its column
// line follows its (synchronised) row strobe.
//
// Optional feature macro: KEYPAD_EMU_BOUNCE_EN
//   When defined, an 8-bit LFSR makes the contact chatter for the first
//   BOUNCE_CYCLES cycles of every press and every release.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   key_valid  key_code is valid
//   key_code   hex key to press (0x0-0xF)
//   key_ready  queue can accept a code (not full)
//   row        row strobes from the scanner, active-high, asynchronous to clk
//   col        column sense lines, active-high, registered
//   busy       queue non-empty or a key still in progress
//   done       one-cycle pulse in the last cycle of each key's release gap
module keypad_emulator #(
  parameter logic [23:0] PRESS_CYCLES  = 24'd1_200_000,
  parameter logic [23:0] GAP_CYCLES    = 24'd600_000,
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] BOUNCE_CYCLES = 16'd2400
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       busy,
  output logic       done
);

  localparam int            AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] counter_q, counter_d;
  logic [1:0]  key_row_q, key_row_d;
  logic [1:0]  key_col_q, key_col_d;
  logic        contact_clean;
  logic        contact;

  // Key-code queue
  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, push, pop;
  logic [3:0]    head_code;
  logic [3:0]    head_pos;

  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);
  assign key_ready  = ~fifo_full;
  // A full queue refuses the push even when a pop frees a slot this same cycle.
  assign push       = key_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head_code  = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= key_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Keypad layout: returns {row, col} of the switch that a code closes.
  function automatic logic [3:0] key_position(input logic [3:0] code);
    case (code)
      4'h1: key_position = {2'd0, 2'd0};
      4'h2: key_position = {2'd0, 2'd1};
      4'h3: key_position = {2'd0, 2'd2};
      4'hC: key_position = {2'd0, 2'd3};
      4'h4: key_position = {2'd1, 2'd0};
      4'h5: key_position = {2'd1, 2'd1};
      4'h6: key_position = {2'd1, 2'd2};
      4'hD: key_position = {2'd1, 2'd3};
      4'h7: key_position = {2'd2, 2'd0};
      4'h8: key_position = {2'd2, 2'd1};
      4'h9: key_position = {2'd2, 2'd2};
      4'hE: key_position = {2'd2, 2'd3};
      4'hA: key_position = {2'd3, 2'd0};
      4'h0: key_position = {2'd3, 2'd1};
      4'hB: key_position = {2'd3, 2'd2};
      4'hF: key_position = {2'd3, 2'd3};
    endcase
  endfunction

  assign head_pos = key_position(head_code);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      counter_q <= 24'd0;
      key_row_q <= 2'd0;
      key_col_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
    end
  end

  // FSM next state and outputs; done is decoded from the last GAP cycle so that
  // busy falls on the cycle right after it.
  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    key_row_d     = key_row_q;
    key_col_d     = key_col_q;
    contact_clean = 1'b0;
    done          = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          key_row_d = head_pos[3:2];
          key_col_d = head_pos[1:0];
          counter_d = PRESS_CYCLES - 24'd1;
          state_d   = PRESS;
        end
      end
      PRESS: begin
        contact_clean = 1'b1;
        if (counter_q == 24'd0) begin
          counter_d = GAP_CYCLES - 24'd1;
          state_d   = GAP;
        end else begin
          counter_d = counter_q - 24'd1;
        end
      end
      GAP: begin
        if (counter_q == 24'd0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          counter_d = counter_q - 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef KEYPAD_EMU_BOUNCE_EN
  // Contact chatter: during the opening window of PRESS and GAP the contact
  // follows lfsr[0]; elapsed cycles are recovered from the down-counter.
  logic [7:0]  lfsr_q;
  logic [23:0] press_elapsed, gap_elapsed;
  logic        in_window;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign press_elapsed = PRESS_CYCLES - 24'd1 - counter_q;
  assign gap_elapsed   = GAP_CYCLES - 24'd1 - counter_q;
  assign in_window     = ((state_q == PRESS) && (press_elapsed < {8'd0, BOUNCE_CYCLES})) ||
                         ((state_q == GAP)   && (gap_elapsed   < {8'd0, BOUNCE_CYCLES}));
  assign contact       = in_window ? lfsr_q[0] : contact_clean;
`else
  assign contact = contact_clean;
`endif

  // Row strobes arrive from another clock domain; two flops before use.
  logic [3:0] row_meta, row_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta <= 4'b0000;
      row_s    <= 4'b0000;
    end else begin
      row_meta <= row;
      row_s    <= row_meta;
    end
  end

  // Only the held key's column can ever be driven, so at most one col bit is set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= 4'b0000;
    end else if (contact && row_s[key_row_q]) begin
      col <= 4'b0001 << key_col_q;
    end else begin
      col <= 4'b0000;
    end
  end

  assign busy = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// tb/tb_keypad_emulator.sv - self-checking bench for keypad_emulator
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       key_ready;
  logic [3:0] row = 4'b0000;
  logic [3:0] col;
  logic       busy;
  logic       done;

  keypad_emulator #(
    .PRESS_CYCLES (24'd20),
    .GAP_CYCLES   (24'd10),
    .FIFO_DEPTH   (4),
    .BOUNCE_CYCLES(16'd4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_ready(key_ready),
    .row      (row),
    .col      (col),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [3:0] exp_q [$];

  localparam logic [3:0] LAYOUT [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hC},
    '{4'h4, 4'h5, 4'h6, 4'hD},
    '{4'h7, 4'h8, 4'h9, 4'hE},
    '{4'hA, 4'h0, 4'hB, 4'hF}
  };

  function automatic logic [3:0] col_of(input logic [3:0] code);
    col_of = 4'b0000;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (LAYOUT[r][c] == code) col_of = 4'b0001 << c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] code);
    chk("send_ready", {31'd0, key_ready}, 32'd1);
    key_code  = code;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pop_compare(input string tag);
    logic [3:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 4'bxxxx;
    chk(tag, {28'd0, col}, {28'd0, e});
  endtask

  // One key from an idle, empty emulator: latency, hold length, done timing.
  task automatic run_key(input logic [3:0] code);
    int t0, n, hi, g;
    logic [3:0] e;
    send(code);
    exp_q.push_back(col_of(code));
    e  = col_of(code);
    t0 = cyc;
    n  = 0;
    while (col == 4'b0000 && n < 40) begin tick(); n++; end
    chk("press_latency", n, 2);
    pop_compare("press_col");
    hi = 1;
    while (hi < 40) begin
      tick();
      if (col == e) hi++;
      else break;
    end
    chk("press_length", hi, 20);
    g = 0;
    while (!done && g < 40) begin tick(); g++; end
    chk("done_time", cyc - t0, 30);
    chk("busy_at_done", {31'd0, busy}, 32'd1);
    tick();
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  // Play out n queued keys; later keys must start exactly 31 cycles apart.
  task automatic drain(input int n_keys);
    int prev, n, g;
    prev = 0;
    for (int k = 0; k < n_keys; k++) begin
      n = 0;
      while (col == 4'b0000 && n < 64) begin tick(); n++; end
      if (k >= 2) chk("key_spacing", cyc - prev, 31);
      prev = cyc;
      pop_compare("drain_col");
      n = 0;
      while (col != 4'b0000 && n < 40) begin tick(); n++; end
    end
    g = 0;
    while (!done && g < 40) begin tick(); g++; end
    chk("drain_done", {31'd0, done}, 32'd1);
    chk("drain_busy_at_done", {31'd0, busy}, 32'd1);
    tick();
    chk("drain_busy_drop", {31'd0, busy}, 32'd0);
    chk("drain_ready", {31'd0, key_ready}, 32'd1);
  endtask

  logic [3:0] seq [4];
  logic [3:0] burst [5];
  logic [3:0] expc;
  int         idx, n;
  logic       seen_a;

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("reset_col", {28'd0, col}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_ready", {31'd0, key_ready}, 32'd1);
    reset = 1'b0;

    // 1: key 5 with row 1 held
    row = 4'b0010;
    repeat (3) tick();
    run_key(4'h5);

    // 2: key A with row strobes cycling one-hot every 8 cycles
    seq[0] = 4'b0100; seq[1] = 4'b1000; seq[2] = 4'b0001; seq[3] = 4'b0010;
    row = seq[0];
    repeat (3) tick();
    send(4'hA);
    for (int o = 1; o <= 31; o++) begin
      tick();
      idx  = (o < 3) ? 0 : (o - 3) / 8;
      expc = (o >= 2 && o <= 21 && seq[idx] == 4'b1000) ? 4'b0001 : 4'b0000;
      chk("scan_col", {28'd0, col}, {28'd0, expc});
      chk("scan_done", {31'd0, done}, (o == 30) ? 32'd1 : 32'd0);
      if (o % 8 == 0) row = seq[o / 8];
    end
    tick();
    chk("scan_busy_drop", {31'd0, busy}, 32'd0);

    // 3: five codes back-to-back with all rows strobed
    row = 4'b1111;
    repeat (3) tick();
    burst[0] = 4'h1; burst[1] = 4'h2; burst[2] = 4'h3; burst[3] = 4'hC; burst[4] = 4'hF;
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_code = burst[i];
      chk("burst_ready", {31'd0, key_ready}, 32'd1);
      tick();
      exp_q.push_back(col_of(burst[i]));
    end
    chk("burst_full", {31'd0, key_ready}, 32'd0);
    key_valid = 1'b0;
    drain(5);

    // 4: reset in the middle of a press, then a normal key
    send(4'h0);
    exp_q.push_back(col_of(4'h0));
    n = 0;
    while (col == 4'b0000 && n < 40) begin tick(); n++; end
    pop_compare("pre_reset_col");
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("midpress_reset_col", {28'd0, col}, 32'd0);
    chk("midpress_reset_busy", {31'd0, busy}, 32'd0);
    chk("midpress_reset_ready", {31'd0, key_ready}, 32'd1);
    tick();
    tick();
    reset = 1'b0;
    row = 4'b0100;
    repeat (3) tick();
    run_key(4'h9);

    // 5: queue full while the head is popped -> push refused, count drops by one
    row = 4'b1111;
    repeat (3) tick();
    burst[0] = 4'h1; burst[1] = 4'h2; burst[2] = 4'h3; burst[3] = 4'hC; burst[4] = 4'h4;
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key_code = burst[i];
      chk("fill_ready", {31'd0, key_ready}, 32'd1);
      tick();
      exp_q.push_back(col_of(burst[i]));
    end
    chk("fill_full", {31'd0, key_ready}, 32'd0);
    key_code = 4'hF;
    n = 0;
    seen_a = 1'b0;
    while (!key_ready && n < 60) begin
      tick();
      n++;
      if (col != 4'b0000 && !seen_a) begin
        seen_a = 1'b1;
        pop_compare("fill_first_col");
      end
    end
    key_valid = 1'b0;
    chk("fill_first_seen", {31'd0, seen_a}, 32'd1);
    chk("full_pop_wait", n, 28);
    chk("full_pop_ready", {31'd0, key_ready}, 32'd1);
    drain(4);

    // 6: key 3 on row 0, contact quality
    row = 4'b0001;
    repeat (3) tick();
`ifdef KEYPAD_EMU_BOUNCE_EN
    send(4'h3);
    repeat (6) tick();
    for (int i = 0; i < 16; i++) begin
      chk("bounce_settled_col", {28'd0, col}, 32'h4);
      tick();
    end
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("bounce_busy_drop", {31'd0, busy}, 32'd0);
`else
    run_key(4'h3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
